// File: rtl/ysyx_22041412_ifu.sv
// Instruction fetch unit: owns the fetch PC, keeps one imem read outstanding, and buffers {pc, instr} in a 2-entry FIFO for decode.
// Latency: request accepted at t, response at t+k (k>=1), if_valid earliest at t+k+1; at most one instruction per 2 cycles.
// Backpressure: a new request is issued only while the FIFO has space, so a response can always be pushed; redirects flush everything.
module ysyx_22041412_ifu #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [63:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [63:0] if_pc,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_run;
    logic [63:0] r_pc;
    logic [63:0] r_inflight_pc;

    logic [63:0] r_fifo_pc    [0:1];
    logic [31:0] r_fifo_instr [0:1];
    logic        r_head;
    logic        r_tail;
    logic [1:0]  r_count;

    logic        w_req_fire;
    logic        w_push;
    logic        w_pop;
    logic [63:0] w_redir_pc;

    // r_run holds requests off until the first clock after reset release, keeping
    // imem_req_valid a pure decode of registered state.
    assign imem_req_valid = r_run && (r_state == S_REQ) && (r_count != 2'd2);
    assign imem_req_addr  = r_pc;

    assign w_req_fire = imem_req_valid && imem_req_ready;
    assign w_push     = (r_state == S_WAIT) && imem_rsp_valid;
    assign w_pop      = if_valid && id_ready;
    assign w_redir_pc = redirect_pc & ~64'h3;

    assign if_valid = (r_count != 2'd0);
    assign if_instr = if_valid ? r_fifo_instr[r_head] : NOP;
    assign if_pc    = if_valid ? r_fifo_pc[r_head]    : 64'h0;

    // Fetch control: PC, in-flight PC and REQ/WAIT/DROP sequencing; redirect overrides everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_REQ;
            r_run         <= 1'b0;
            r_pc          <= RESET_PC;
            r_inflight_pc <= 64'h0;
        end else begin
            r_run <= 1'b1;
            if (redirect_valid) begin
                r_pc <= w_redir_pc;
                case (r_state)
                    S_REQ:   r_state <= w_req_fire ? S_DROP : S_REQ;
                    S_WAIT:  r_state <= imem_rsp_valid ? S_REQ : S_DROP;
                    S_DROP:  r_state <= imem_rsp_valid ? S_REQ : S_DROP;
                    default: r_state <= S_REQ;
                endcase
            end else begin
                case (r_state)
                    S_REQ: begin
                        if (w_req_fire) begin
                            r_inflight_pc <= r_pc;
                            r_pc          <= r_pc + 64'd4;
                            r_state       <= S_WAIT;
                        end
                    end
                    S_WAIT:  if (imem_rsp_valid) r_state <= S_REQ;
                    S_DROP:  if (imem_rsp_valid) r_state <= S_REQ;
                    default: r_state <= S_REQ;
                endcase
            end
        end
    end

    // Two-entry {pc, instr} FIFO; a redirect empties it and ignores same-cycle push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head          <= 1'b0;
            r_tail          <= 1'b0;
            r_count         <= 2'd0;
            r_fifo_pc[0]    <= 64'h0;
            r_fifo_pc[1]    <= 64'h0;
            r_fifo_instr[0] <= 32'h0;
            r_fifo_instr[1] <= 32'h0;
        end else if (redirect_valid) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_pc[r_tail]    <= r_inflight_pc;
                r_fifo_instr[r_tail] <= imem_rsp_data;
                r_tail               <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule
